// File: rtl/nv_nvdla_sdp_mrdma_ig_gen_if.sv
// SDP MRDMA ingress request bundle:
// DMA read request channel plus context-queue push channel.
interface nv_nvdla_sdp_mrdma_ig_gen_if #(
  parameter int ADDR_W = 64
);
  logic              dma_rd_req_pvld;
  logic              dma_rd_req_prdy;
  logic [ADDR_W-1:0] dma_rd_req_addr;
  logic [2:0]        dma_rd_req_size;
  logic              ig2cq_pvld;
  logic              ig2cq_prdy;
  logic [13:0]       ig2cq_pd;

  modport master (
    output dma_rd_req_pvld,
    output dma_rd_req_addr,
    output dma_rd_req_size,
    output ig2cq_pvld,
    output ig2cq_pd,
    input  dma_rd_req_prdy,
    input  ig2cq_prdy
  );

  modport slave (
    input  dma_rd_req_pvld,
    input  dma_rd_req_addr,
    input  dma_rd_req_size,
    input  ig2cq_pvld,
    input  ig2cq_pd,
    output dma_rd_req_prdy,
    output ig2cq_prdy
  );
endinterface

// File: rtl/nv_nvdla_sdp_mrdma_ig_gen.sv
// SDP MRDMA ingress generator: walks surface/line/atom cube,
// issuing DMA reads and pushing matching context-queue entries.
module nv_nvdla_sdp_mrdma_ig_gen #(
  parameter int ADDR_W    = 64,
  parameter int MAX_ATOMS = 8
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              op_load,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [12:0]       cfg_width_m1,
  input  logic [12:0]       cfg_height_m1,
  input  logic [12:0]       cfg_surf_m1,
  input  logic [ADDR_W-1:0] cfg_line_stride,
  input  logic [ADDR_W-1:0] cfg_surf_stride,
  nv_nvdla_sdp_mrdma_ig_gen_if.master rd,
  output logic              op_busy,
  output logic              op_done
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_e;

  localparam logic [12:0] MAXM1 = 13'(MAX_ATOMS - 1);
  localparam logic [ADDR_W-1:0] ALGN = ~ADDR_W'(32'h1f);

  state_e            state_q, state_d;
  logic [12:0]       width_q, width_d;
  logic [12:0]       height_q, height_d;
  logic [12:0]       surf_q, surf_d;
  logic [ADDR_W-1:0] lstr_q, lstr_d;
  logic [ADDR_W-1:0] sstr_q, sstr_d;
  logic [12:0]       atom_q, atom_d;
  logic [12:0]       line_q, line_d;
  logic [12:0]       scnt_q, scnt_d;
  logic [ADDR_W-1:0] req_q, req_d;
  logic [ADDR_W-1:0] lbase_q, lbase_d;
  logic [ADDR_W-1:0] sbase_q, sbase_d;

  logic [12:0]       rem_m1;
  logic              eol, last_line, last_surf;
  logic              cmd_vld, fire;
  logic [2:0]        size;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] base_al;

  always_comb begin
    rem_m1    = width_q - atom_q;
    eol       = rem_m1 <= MAXM1;
    size      = eol ? rem_m1[2:0] : MAXM1[2:0];
    last_line = line_q == height_q;
    last_surf = scnt_q == surf_q;
    cmd_vld   = state_q == GEN;
    fire      = cmd_vld & rd.dma_rd_req_prdy
              & rd.ig2cq_prdy;
    step      = (ADDR_W'(size) + ADDR_W'(1)) << 5;
    base_al   = cfg_base_addr & ALGN;
  end

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    surf_d   = surf_q;
    lstr_d   = lstr_q;
    sstr_d   = sstr_q;
    atom_d   = atom_q;
    line_d   = line_q;
    scnt_d   = scnt_q;
    req_d    = req_q;
    lbase_d  = lbase_q;
    sbase_d  = sbase_q;
    case (state_q)
      IDLE: begin
        if (op_load) begin
          state_d  = GEN;
          width_d  = cfg_width_m1;
          height_d = cfg_height_m1;
          surf_d   = cfg_surf_m1;
          lstr_d   = cfg_line_stride & ALGN;
          sstr_d   = cfg_surf_stride & ALGN;
          atom_d   = '0;
          line_d   = '0;
          scnt_d   = '0;
          req_d    = base_al;
          lbase_d  = base_al;
          sbase_d  = base_al;
        end
      end
      GEN: begin
        if (fire) begin
          if (!eol) begin
            atom_d = atom_q + {10'b0, size} + 13'd1;
            req_d  = req_q + step;
          end else begin
            atom_d = '0;
            if (!last_line) begin
              line_d  = line_q + 13'd1;
              lbase_d = lbase_q + lstr_q;
              req_d   = lbase_d;
            end else begin
              line_d = '0;
              // next surface: line base reloads from new surface base
              if (!last_surf) begin
                scnt_d  = scnt_q + 13'd1;
                sbase_d = sbase_q + sstr_q;
                lbase_d = sbase_d;
                req_d   = sbase_d;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q  <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      surf_q   <= '0;
      lstr_q   <= '0;
      sstr_q   <= '0;
      atom_q   <= '0;
      line_q   <= '0;
      scnt_q   <= '0;
      req_q    <= '0;
      lbase_q  <= '0;
      sbase_q  <= '0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      surf_q   <= surf_d;
      lstr_q   <= lstr_d;
      sstr_q   <= sstr_d;
      atom_q   <= atom_d;
      line_q   <= line_d;
      scnt_q   <= scnt_d;
      req_q    <= req_d;
      lbase_q  <= lbase_d;
      sbase_q  <= sbase_d;
    end
  end

  // each channel's valid waits on the other's ready: joint accept
  assign rd.dma_rd_req_pvld = cmd_vld & rd.ig2cq_prdy;
  assign rd.ig2cq_pvld      = cmd_vld & rd.dma_rd_req_prdy;
  assign rd.dma_rd_req_addr = cmd_vld ? req_q : '0;
  assign rd.dma_rd_req_size = cmd_vld ? size : '0;
  assign rd.ig2cq_pd = cmd_vld ?
    {8'b0, eol & last_line & last_surf,
     eol & last_line, eol, size} : '0;
  assign op_busy = state_q == GEN;
  assign op_done = state_q == DONE;

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_ig_gen.sv
// Bench for nv_nvdla_sdp_mrdma_ig_gen: cube-walk reference
// model with per-cycle compare plus literal spot checks.
module tb_nv_nvdla_sdp_mrdma_ig_gen;

  typedef struct {
    logic [63:0] a;
    logic [2:0]  s;
    logic [13:0] pd;
  } req_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        op_load = 1'b0;
  logic [63:0] base = '0;
  logic [63:0] lstr = '0;
  logic [63:0] sstr = '0;
  logic [12:0] wm = '0;
  logic [12:0] hm = '0;
  logic [12:0] sm = '0;
  logic        busy, done;

  nv_nvdla_sdp_mrdma_ig_gen_if #(.ADDR_W(64)) rd();

  nv_nvdla_sdp_mrdma_ig_gen #(.ADDR_W(64), .MAX_ATOMS(8)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .op_load         (op_load),
    .cfg_base_addr   (base),
    .cfg_width_m1    (wm),
    .cfg_height_m1   (hm),
    .cfg_surf_m1     (sm),
    .cfg_line_stride (lstr),
    .cfg_surf_stride (sstr),
    .rd              (rd),
    .op_busy         (busy),
    .op_done         (done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          phase = 0;
  int          dma_f = 0;
  int          cq_f = 0;
  bit          tog = 1'b0;
  req_t        exq[$];
  logic [63:0] fa[$];
  logic [63:0] fp[$];

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  // expected request list from cube geometry
  task automatic build();
    logic [63:0] b, ls, ss;
    int w, h, s;
    b  = base & ~64'h1f;
    ls = lstr & ~64'h1f;
    ss = sstr & ~64'h1f;
    w  = int'(wm);
    h  = int'(hm);
    s  = int'(sm);
    for (int si = 0; si <= s; si++) begin
      for (int li = 0; li <= h; li++) begin
        int a;
        a = 0;
        while (a <= w) begin
          req_t r;
          int n;
          bit e, el, es;
          n = (w + 1 - a > 8) ? 8 : w + 1 - a;
          e  = (a + n == w + 1);
          el = e && (li == h);
          es = el && (si == s);
          r.a  = b + 64'(si) * ss + 64'(li) * ls + 64'(a) * 64'd32;
          r.s  = 3'(n - 1);
          r.pd = {8'b0, es, el, e, 3'(n - 1)};
          exq.push_back(r);
          a += n;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_dma_pvld", 64'(rd.dma_rd_req_pvld), 0);
      chk("rst_cq_pvld", 64'(rd.ig2cq_pvld), 0);
      chk("rst_addr", rd.dma_rd_req_addr, 0);
      chk("rst_pd", 64'(rd.ig2cq_pd), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      phase = 0;
      exq.delete();
    end else begin
      chk("dma_pvld", 64'(rd.dma_rd_req_pvld),
          64'((phase == 1) && rd.ig2cq_prdy));
      chk("cq_pvld", 64'(rd.ig2cq_pvld),
          64'((phase == 1) && rd.dma_rd_req_prdy));
      chk("busy", 64'(busy), 64'(phase == 1));
      chk("done", 64'(done), 64'(phase == 2));
      if (rd.dma_rd_req_pvld && rd.dma_rd_req_prdy) dma_f++;
      if (rd.ig2cq_pvld && rd.ig2cq_prdy) cq_f++;
      if (phase == 1 && rd.dma_rd_req_prdy && rd.ig2cq_prdy) begin
        fa.push_back(rd.dma_rd_req_addr);
        fp.push_back(64'(rd.ig2cq_pd));
        if (exq.size() == 0) begin
          chk("extra_req", 64'(1), 64'(0));
        end else begin
          req_t r;
          r = exq.pop_front();
          chk("addr", rd.dma_rd_req_addr, r.a);
          chk("size", 64'(rd.dma_rd_req_size), 64'(r.s));
          chk("pd", 64'(rd.ig2cq_pd), 64'(r.pd));
        end
        if (exq.size() == 0) phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end else if (phase == 0 && op_load) begin
        build();
        phase = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) rd.dma_rd_req_prdy = ~rd.dma_rd_req_prdy;
  endtask

  task automatic cfg(logic [63:0] b, logic [12:0] w,
                     logic [12:0] h, logic [12:0] s,
                     logic [63:0] l, logic [63:0] ss);
    base = b; wm = w; hm = h; sm = s; lstr = l; sstr = ss;
    fa.delete();
    fp.delete();
  endtask

  task automatic start();
    op_load = 1'b1;
    step();
    op_load = 1'b0;
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while (phase != 0 && n < 3000) begin
      step();
      n++;
    end
    chk({nm, "_timeout"}, 64'(phase != 0), 0);
    step();
  endtask

  initial begin
    rd.dma_rd_req_prdy = 1'b1;
    rd.ig2cq_prdy = 1'b1;
    repeat (3) step();
    rstn = 1'b1;
    step();

    // t1: two requests, 8 + 2 atoms; late cfg change ignored
    cfg(64'h1000, 9, 0, 0, 0, 0);
    start();
    base = 64'hdead_0000;
    wait_idle("t1");
    chk("t1_n", 64'(fa.size()), 2);
    chk("t1_a0", fa[0], 64'h1000);
    chk("t1_p0", fp[0], 64'h007);
    chk("t1_a1", fa[1], 64'h1100);
    chk("t1_p1", fp[1], 64'h039);

    // t2: 2 surfaces x 2 lines x one full request
    cfg(0, 7, 1, 1, 64'h400, 64'h10000);
    start();
    wait_idle("t2");
    chk("t2_n", 64'(fa.size()), 4);
    chk("t2_a1", fa[1], 64'h400);
    chk("t2_a2", fa[2], 64'h10000);
    chk("t2_a3", fa[3], 64'h10400);
    chk("t2_p1", fp[1], 64'h01f);
    chk("t2_p2", fp[2], 64'h00f);
    chk("t2_p3", fp[3], 64'h03f);

    // t3: context queue full for 20 cycles
    cfg(64'h1000, 9, 0, 0, 0, 0);
    rd.ig2cq_prdy = 1'b0;
    start();
    repeat (20) step();
    rd.ig2cq_prdy = 1'b1;
    wait_idle("t3");
    chk("t3_n", 64'(fa.size()), 2);
    chk("t3_a1", fa[1], 64'h1100);

    // t4: toggling DMA ready, unaligned strides/base
    dma_f = 0;
    cq_f = 0;
    cfg(64'h2013, 16, 2, 1, 64'h30f, 64'h8011);
    tog = 1'b1;
    start();
    wait_idle("t4");
    tog = 1'b0;
    rd.dma_rd_req_prdy = 1'b1;
    chk("t4_n", 64'(fa.size()), 18);
    chk("t4_cq_eq_dma", 64'(cq_f), 64'(dma_f));
    chk("t4_a2", fa[2], 64'h2200);

    // t5: second op_load while generating is ignored
    cfg(64'h4000, 20, 1, 0, 64'h1000, 0);
    start();
    step();
    start();
    wait_idle("t5");
    chk("t5_n", 64'(fa.size()), 6);

    // boundaries: all-zero, width 1, address wrap
    cfg(0, 0, 0, 0, 0, 0);
    start();
    wait_idle("zero");
    chk("zero_n", 64'(fa.size()), 1);
    chk("zero_p", fp[0], 64'h038);
    cfg(64'h100, 0, 2, 0, 64'h20, 0);
    start();
    wait_idle("w1");
    chk("w1_n", 64'(fa.size()), 3);
    chk("w1_p0", fp[0], 64'h008);
    cfg(64'hffff_ffff_ffff_ffe0, 9, 0, 0, 0, 0);
    start();
    wait_idle("wrap");
    chk("wrap_a1", fa[1], 64'h0000_0000_0000_00e0);

    // t6: reset mid-op, then fresh op with new cfg
    cfg(64'h8000, 40, 3, 1, 64'h800, 64'h40000);
    start();
    repeat (3) step();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
    chk("t6_idle_pvld", 64'(rd.dma_rd_req_pvld), 0);
    chk("t6_idle_busy", 64'(busy), 0);
    cfg(64'h9000, 2, 0, 0, 0, 0);
    start();
    wait_idle("t6");
    chk("t6_n", 64'(fa.size()), 1);
    chk("t6_a0", fa[0], 64'h9000);
    chk("t6_p0", fp[0], 64'h03a);
    chk("model_empty", 64'(exq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
